// File: rtl/scr1_dmem_vec_serializer_pkg.sv
// scr1_dmem_vec_serializer_pkg: memory interface types shared by the LSU-side vector serializer
package scr1_dmem_vec_serializer_pkg;
  localparam int SCR1_LANE = 4;
  localparam int SCR1_DMEM_AWIDTH = 32;
  typedef logic [SCR1_LANE-1:0][31:0] type_vector;
  typedef enum logic {SCR1_MEM_CMD_RD, SCR1_MEM_CMD_WR} type_scr1_mem_cmd_e;
  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE,
    SCR1_MEM_WIDTH_HWORD,
    SCR1_MEM_WIDTH_WORD,
    SCR1_MEM_WIDTH_VECTOR
  } type_scr1_mem_width_e;
  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY,
    SCR1_MEM_RESP_RDY_OK,
    SCR1_MEM_RESP_RDY_ER
  } type_scr1_mem_resp_e;
  typedef enum logic [1:0] {
    SCR1_SER_IDLE,
    SCR1_SER_REQ,
    SCR1_SER_WAIT,
    SCR1_SER_RSP
  } type_scr1_ser_fsm_e;
endpackage

// File: rtl/scr1_dmem_vec_serializer.sv
// scr1_dmem_vec_serializer: splits vector DMEM requests into sequential 32-bit beats, one response per request
module scr1_dmem_vec_serializer
  import scr1_dmem_vec_serializer_pkg::*;
#(
  parameter int LANE   = SCR1_LANE,
  parameter int AWIDTH = SCR1_DMEM_AWIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lsu2dmem_req,
  input  type_scr1_mem_cmd_e     lsu2dmem_cmd,
  input  type_scr1_mem_width_e   lsu2dmem_width,
  input  logic [AWIDTH-1:0]      lsu2dmem_addr,
  input  logic [LANE-1:0][31:0]  lsu2dmem_wdata,
  output logic                   dmem2lsu_req_ack,
  output logic [LANE-1:0][31:0]  dmem2lsu_rdata,
  output type_scr1_mem_resp_e    dmem2lsu_resp,
  output logic                   ser2mem_req,
  output type_scr1_mem_cmd_e     ser2mem_cmd,
  output type_scr1_mem_width_e   ser2mem_width,
  output logic [AWIDTH-1:0]      ser2mem_addr,
  output logic [31:0]            ser2mem_wdata,
  input  logic                   mem2ser_req_ack,
  input  logic [31:0]            mem2ser_rdata,
  input  type_scr1_mem_resp_e    mem2ser_resp
);
  localparam int BW = (LANE > 1) ? $clog2(LANE) : 1;
  type_scr1_ser_fsm_e   state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 err_q, err_d;
  type_scr1_mem_cmd_e   cmd_q, cmd_d;
  type_scr1_mem_width_e width_q, width_d;
  logic [AWIDTH-1:0]    addr_q, addr_d;
  logic [LANE-1:0][31:0] wdata_q, wdata_d, rbuf_q, rbuf_d;
  logic                 is_vec, last;
  assign is_vec = width_q == SCR1_MEM_WIDTH_VECTOR;
  assign last   = !is_vec || beat_q == BW'(LANE - 1);
  assign dmem2lsu_req_ack = state_q == SCR1_SER_IDLE && lsu2dmem_req;
  assign dmem2lsu_resp    = state_q != SCR1_SER_RSP ? SCR1_MEM_RESP_NOTRDY
                          : err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
  assign dmem2lsu_rdata   = rbuf_q;
  assign ser2mem_req      = state_q == SCR1_SER_REQ;
  assign ser2mem_cmd      = cmd_q;
  assign ser2mem_width    = is_vec ? SCR1_MEM_WIDTH_WORD : width_q;
  // word index advances per beat; the sub-word offset and any wrap are left as-is
  assign ser2mem_addr     = is_vec ? {addr_q[AWIDTH-1:2] + (AWIDTH-2)'(beat_q), addr_q[1:0]} : addr_q;
  assign ser2mem_wdata    = wdata_q[is_vec ? beat_q : '0];
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    cmd_d   = cmd_q;
    width_d = width_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      SCR1_SER_IDLE: if (lsu2dmem_req) begin
        cmd_d   = lsu2dmem_cmd;
        width_d = lsu2dmem_width;
        addr_d  = lsu2dmem_addr;
        wdata_d = lsu2dmem_wdata;
        rbuf_d  = '0;
        beat_d  = '0;
        err_d   = 1'b0;
        state_d = SCR1_SER_REQ;
      end
      SCR1_SER_REQ: if (mem2ser_req_ack) state_d = SCR1_SER_WAIT;
      SCR1_SER_WAIT: if (mem2ser_resp == SCR1_MEM_RESP_RDY_ER) begin
        err_d   = 1'b1;
        state_d = SCR1_SER_RSP;
      end else if (mem2ser_resp == SCR1_MEM_RESP_RDY_OK) begin
        if (cmd_q == SCR1_MEM_CMD_RD) rbuf_d[is_vec ? beat_q : '0] = mem2ser_rdata;
        state_d = last ? SCR1_SER_RSP : SCR1_SER_REQ;
        beat_d  = last ? beat_q : beat_q + 1'b1;
      end
      default: state_d = SCR1_SER_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCR1_SER_IDLE;
      beat_q  <= '0;
      err_q   <= 1'b0;
      cmd_q   <= SCR1_MEM_CMD_RD;
      width_q <= SCR1_MEM_WIDTH_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      cmd_q   <= cmd_d;
      width_q <= width_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
    end
  end
endmodule

// File: tb/tb_scr1_dmem_vec_serializer.sv
// tb_scr1_dmem_vec_serializer: directed scenarios against a behavioural scalar memory
module tb_scr1_dmem_vec_serializer;
  import scr1_dmem_vec_serializer_pkg::*;
  localparam int LANE = SCR1_LANE;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic                  lsu2dmem_req = 1'b0;
  type_scr1_mem_cmd_e    lsu2dmem_cmd = SCR1_MEM_CMD_RD;
  type_scr1_mem_width_e  lsu2dmem_width = SCR1_MEM_WIDTH_WORD;
  logic [31:0]           lsu2dmem_addr = '0;
  logic [LANE-1:0][31:0] lsu2dmem_wdata = '0;
  logic                  dmem2lsu_req_ack;
  logic [LANE-1:0][31:0] dmem2lsu_rdata;
  type_scr1_mem_resp_e   dmem2lsu_resp;
  logic                  ser2mem_req;
  type_scr1_mem_cmd_e    ser2mem_cmd;
  type_scr1_mem_width_e  ser2mem_width;
  logic [31:0]           ser2mem_addr;
  logic [31:0]           ser2mem_wdata;
  logic                  mem2ser_req_ack = 1'b0;
  logic [31:0]           mem2ser_rdata = '0;
  type_scr1_mem_resp_e   mem2ser_resp = SCR1_MEM_RESP_NOTRDY;
  scr1_dmem_vec_serializer dut (
    .clk(clk), .rst(rst),
    .lsu2dmem_req(lsu2dmem_req), .lsu2dmem_cmd(lsu2dmem_cmd), .lsu2dmem_width(lsu2dmem_width),
    .lsu2dmem_addr(lsu2dmem_addr), .lsu2dmem_wdata(lsu2dmem_wdata),
    .dmem2lsu_req_ack(dmem2lsu_req_ack), .dmem2lsu_rdata(dmem2lsu_rdata), .dmem2lsu_resp(dmem2lsu_resp),
    .ser2mem_req(ser2mem_req), .ser2mem_cmd(ser2mem_cmd), .ser2mem_width(ser2mem_width),
    .ser2mem_addr(ser2mem_addr), .ser2mem_wdata(ser2mem_wdata),
    .mem2ser_req_ack(mem2ser_req_ack), .mem2ser_rdata(mem2ser_rdata), .mem2ser_resp(mem2ser_resp)
  );
  typedef struct {
    logic [31:0]          addr;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [31:0]          wdata;
  } beat_t;
  beat_t       log_q[$];
  beat_t       mb;
  logic [31:0] mem_arr [logic [31:0]];
  int stall = 0, stall_cnt = 0, err_beat = -1, mute_beat = -1, req_cycles = 0;
  bit pend = 0;
  int vectors = 0, errors = 0;
  // memory: acks after `stall` request cycles, responds the following cycle; unknown reads return the address
  always @(negedge clk) begin
    mem2ser_req_ack = 1'b0;
    mem2ser_resp = SCR1_MEM_RESP_NOTRDY;
    mem2ser_rdata = '0;
    if (pend) begin
      if (log_q.size() - 1 != mute_beat) begin
        pend = 0;
        mb = log_q[log_q.size()-1];
        if (log_q.size() - 1 == err_beat) mem2ser_resp = SCR1_MEM_RESP_RDY_ER;
        else begin
          mem2ser_resp = SCR1_MEM_RESP_RDY_OK;
          if (mb.cmd == SCR1_MEM_CMD_WR) mem_arr[mb.addr] = mb.wdata;
          else mem2ser_rdata = mem_arr.exists(mb.addr) ? mem_arr[mb.addr] : mb.addr;
        end
      end
    end else if (ser2mem_req) begin
      req_cycles++;
      if (stall_cnt < stall) stall_cnt++;
      else begin
        stall_cnt = 0;
        mem2ser_req_ack = 1'b1;
        log_q.push_back('{ser2mem_addr, ser2mem_cmd, ser2mem_width, ser2mem_wdata});
        pend = 1;
      end
    end
  end
  task automatic send(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                      input logic [31:0] a, input logic [LANE-1:0][31:0] d, output logic ack);
    log_q.delete();
    req_cycles = 0;
    @(negedge clk);
    lsu2dmem_req = 1'b1;
    lsu2dmem_cmd = c;
    lsu2dmem_width = w;
    lsu2dmem_addr = a;
    lsu2dmem_wdata = d;
    #1 ack = dmem2lsu_req_ack;
    @(posedge clk);
    #1 lsu2dmem_req = 1'b0;
  endtask
  task automatic wait_resp(output int lat, output type_scr1_mem_resp_e r, output logic [LANE-1:0][31:0] rd);
    lat = -1;
    r = SCR1_MEM_RESP_NOTRDY;
    rd = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (dmem2lsu_resp != SCR1_MEM_RESP_NOTRDY) begin
        lat = k;
        r = dmem2lsu_resp;
        rd = dmem2lsu_rdata;
        break;
      end
    end
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (ser2mem_req !== 1'b0) begin errors++; $display("FAIL reset_ser_req got %b exp 0", ser2mem_req); end
    vectors++; if (dmem2lsu_req_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", dmem2lsu_req_ack); end
    vectors++; if (dmem2lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL reset_resp got %0d exp 0", dmem2lsu_resp); end
    vectors++; if (dmem2lsu_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", dmem2lsu_rdata); end
    rst = 1'b0;
  endtask
  task automatic test_scalar_lw(input string tag);
    logic ack; int lat; type_scr1_mem_resp_e r; logic [LANE-1:0][31:0] rd, exp;
    exp = '0;
    exp[0] = 32'hDEADBEEF;
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, '0, ack);
    wait_resp(lat, r, rd);
    vectors++; if (ack !== 1'b1) begin errors++; $display("FAIL %s_ack got %b exp 1", tag, ack); end
    vectors++; if (lat != 3) begin errors++; $display("FAIL %s_latency got %0d exp 3", tag, lat); end
    vectors++; if (r !== SCR1_MEM_RESP_RDY_OK) begin errors++; $display("FAIL %s_resp got %0d exp 1", tag, r); end
    vectors++; if (rd !== exp) begin errors++; $display("FAIL %s_rdata got %h exp %h", tag, rd, exp); end
    vectors++; if (log_q.size() != 1) begin errors++; $display("FAIL %s_beats got %0d exp 1", tag, log_q.size()); end
    else begin
      vectors++; if (log_q[0].addr !== 32'h100) begin errors++; $display("FAIL %s_addr got %h exp 100", tag, log_q[0].addr); end
      vectors++; if (log_q[0].width !== SCR1_MEM_WIDTH_WORD) begin errors++; $display("FAIL %s_width got %0d exp 2", tag, log_q[0].width); end
    end
    @(negedge clk);
    vectors++; if (dmem2lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL %s_resp_once got %0d exp 0", tag, dmem2lsu_resp); end
  endtask
  task automatic test_vector_load();
    logic ack; int lat; type_scr1_mem_resp_e r; logic [LANE-1:0][31:0] rd, exp;
    exp = {32'h20C, 32'h208, 32'h204, 32'h200};
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h200, '0, ack);
    wait_resp(lat, r, rd);
    vectors++; if (lat != 1 + 2 * LANE) begin errors++; $display("FAIL vld_latency got %0d exp %0d", lat, 1 + 2 * LANE); end
    vectors++; if (r !== SCR1_MEM_RESP_RDY_OK) begin errors++; $display("FAIL vld_resp got %0d exp 1", r); end
    vectors++; if (rd !== exp) begin errors++; $display("FAIL vld_rdata got %h exp %h", rd, exp); end
    vectors++; if (log_q.size() != LANE) begin errors++; $display("FAIL vld_beats got %0d exp %0d", log_q.size(), LANE); end
    else for (int i = 0; i < LANE; i++) begin
      vectors++; if (log_q[i].addr !== 32'h200 + 4 * i || log_q[i].width !== SCR1_MEM_WIDTH_WORD) begin
        errors++; $display("FAIL vld_beat%0d got addr %h width %0d exp addr %h width 2", i, log_q[i].addr, log_q[i].width, 32'h200 + 4 * i);
      end
    end
    @(negedge clk);
    vectors++; if (dmem2lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL vld_resp_once got %0d exp 0", dmem2lsu_resp); end
  endtask
  task automatic test_vector_store_stall();
    logic ack; int lat; type_scr1_mem_resp_e r; logic [LANE-1:0][31:0] rd;
    stall = 2;
    send(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'h300, {32'd4, 32'd3, 32'd2, 32'd1}, ack);
    wait_resp(lat, r, rd);
    stall = 0;
    vectors++; if (r !== SCR1_MEM_RESP_RDY_OK) begin errors++; $display("FAIL vst_resp got %0d exp 1", r); end
    vectors++; if (lat != 1 + 4 * LANE) begin errors++; $display("FAIL vst_latency got %0d exp %0d", lat, 1 + 4 * LANE); end
    vectors++; if (req_cycles != 3 * LANE) begin errors++; $display("FAIL vst_req_held got %0d exp %0d", req_cycles, 3 * LANE); end
    vectors++; if (log_q.size() != LANE) begin errors++; $display("FAIL vst_beats got %0d exp %0d", log_q.size(), LANE); end
    for (int i = 0; i < LANE; i++) begin
      vectors++; if (!mem_arr.exists(32'h300 + 4 * i) || mem_arr[32'h300 + 4 * i] !== 32'(i + 1)) begin
        errors++; $display("FAIL vst_mem%0d got %h exp %h", i, mem_arr.exists(32'h300 + 4 * i) ? mem_arr[32'h300 + 4 * i] : 32'hx, i + 1);
      end
    end
    @(negedge clk);
    vectors++; if (dmem2lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL vst_resp_once got %0d exp 0", dmem2lsu_resp); end
  endtask
  task automatic test_vector_error();
    logic ack; int lat; type_scr1_mem_resp_e r; logic [LANE-1:0][31:0] rd;
    err_beat = 2;
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h600, '0, ack);
    wait_resp(lat, r, rd);
    vectors++; if (r !== SCR1_MEM_RESP_RDY_ER) begin errors++; $display("FAIL verr_resp got %0d exp 2", r); end
    vectors++; if (lat != 7) begin errors++; $display("FAIL verr_latency got %0d exp 7", lat); end
    @(negedge clk);
    vectors++; if (dmem2lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL verr_resp_once got %0d exp 0", dmem2lsu_resp); end
    repeat (3) @(negedge clk);
    vectors++; if (log_q.size() != 3) begin errors++; $display("FAIL verr_beats got %0d exp 3", log_q.size()); end
    err_beat = -1;
  endtask
  task automatic test_sb();
    logic ack; int lat; type_scr1_mem_resp_e r; logic [LANE-1:0][31:0] rd;
    send(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h403, {32'h0, 32'h0, 32'h0, 32'hAB}, ack);
    wait_resp(lat, r, rd);
    vectors++; if (r !== SCR1_MEM_RESP_RDY_OK || lat != 3) begin errors++; $display("FAIL sb_resp got %0d at %0d exp 1 at 3", r, lat); end
    vectors++; if (log_q.size() != 1) begin errors++; $display("FAIL sb_beats got %0d exp 1", log_q.size()); end
    else begin
      vectors++; if (log_q[0].width !== SCR1_MEM_WIDTH_BYTE) begin errors++; $display("FAIL sb_width got %0d exp 0", log_q[0].width); end
      vectors++; if (log_q[0].addr !== 32'h403) begin errors++; $display("FAIL sb_addr got %h exp 403", log_q[0].addr); end
      vectors++; if (log_q[0].wdata !== 32'hAB) begin errors++; $display("FAIL sb_wdata got %h exp ab", log_q[0].wdata); end
      vectors++; if (log_q[0].cmd !== SCR1_MEM_CMD_WR) begin errors++; $display("FAIL sb_cmd got %0d exp 1", log_q[0].cmd); end
    end
  endtask
  task automatic test_reset_midflight();
    logic ack; bit seen = 0; bit got_resp = 0;
    mute_beat = 1;
    send(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h700, '0, ack);
    for (int k = 0; k < 50 && log_q.size() < 2; k++) begin
      @(negedge clk);
      if (dmem2lsu_resp != SCR1_MEM_RESP_NOTRDY) got_resp = 1;
      #1;
    end
    seen = log_q.size() == 2;
    vectors++; if (!seen) begin errors++; $display("FAIL rstmid_beat1 got %0d beats exp 2", log_q.size()); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (ser2mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_ser_req got %b exp 0", ser2mem_req); end
    vectors++; if (dmem2lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL rstmid_resp got %0d exp 0", dmem2lsu_resp); end
    vectors++; if (dmem2lsu_rdata !== '0) begin errors++; $display("FAIL rstmid_rdata got %h exp 0", dmem2lsu_rdata); end
    vectors++; if (dmem2lsu_req_ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack got %b exp 0", dmem2lsu_req_ack); end
    mute_beat = -1;
    repeat (3) begin
      @(negedge clk);
      if (dmem2lsu_resp != SCR1_MEM_RESP_NOTRDY || ser2mem_req) got_resp = 1;
    end
    vectors++; if (got_resp) begin errors++; $display("FAIL rstmid_no_resp got activity exp none"); end
    vectors++; if (pend) begin errors++; $display("FAIL rstmid_late_resp got pending exp delivered"); end
    test_scalar_lw("post_rst");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
  initial begin
    mem_arr[32'h100] = 32'hDEADBEEF;
    test_reset();
    test_scalar_lw("lw");
    test_vector_load();
    test_vector_store_stall();
    test_vector_error();
    test_sb();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
